// File: rtl/rr_output_allocator_if.sv
// Output-port allocator bundle: request/flit-type/credit inputs from the
// router side, grant/transfer/credit status back out of the allocator.
interface rr_output_allocator_if #(
    parameter int CRED_W = 3
);
    logic [4:0]        req;
    logic [2:0]        flit_id;
    logic              credit_in;
    logic [4:0]        grant;
    logic              xfer;
    logic [CRED_W-1:0] credits;
    logic              timeout_err;
    logic              credit_err;

    modport master (
        output req, flit_id, credit_in,
        input  grant, xfer, credits, timeout_err, credit_err
    );

    modport slave (
        input  req, flit_id, credit_in,
        output grant, xfer, credits, timeout_err, credit_err
    );
endinterface

// File: rtl/rr_output_allocator.sv
// Round-robin output allocator for one port of a 5-port mesh router.
// Holds a grant for a whole packet, gates flits on downstream credits and
// releases a stuck packet through a stall watchdog.
module rr_output_allocator #(
    parameter int BUF_DEPTH = 4,
    parameter int CRED_W    = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_output_allocator_if.slave bus
);
    localparam logic [CRED_W-1:0] CRED_FULL  = CRED_W'(BUF_DEPTH);
    localparam logic [CRED_W-1:0] CRED_ONE   = CRED_W'(1);
    localparam logic [11:0]       STALL_LAST = 12'(TIMEOUT - 1);
    localparam logic [2:0]        FLIT_HEAD  = 3'b001;
    localparam logic [2:0]        FLIT_BODY  = 3'b010;
    localparam logic [2:0]        FLIT_TAIL  = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        ACTIVE = 2'b10
    } state_t;

    state_t            state_reg, state_next;
    logic [4:0]        grant_reg, grant_next;
    logic [2:0]        ptr_reg, ptr_next;
    logic [2:0]        win_reg, win_next;
    logic [11:0]       stall_reg, stall_next;
    logic [CRED_W-1:0] credits_reg, credits_next;
    logic              timeout_err_reg, timeout_err_next;
    logic              credit_err_reg, credit_err_next;

    logic              pick_valid;
    logic [2:0]        pick_idx;
    logic [2:0]        win_inc;
    logic              flit_valid;
    logic              xfer;

    // Round-robin search: first requester at or after ptr, wrapping mod 5.
    // Walking the offsets high-to-low lets the smallest offset win last.
    always_comb begin
        logic [3:0] sum;
        logic [2:0] idx;
        pick_valid = 1'b0;
        pick_idx   = 3'd0;
        sum        = 4'd0;
        idx        = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            sum = {1'b0, ptr_reg} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (bus.req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // Transfer qualification: owner still requesting, credit available, legal flit.
    always_comb begin
        flit_valid = (bus.flit_id == FLIT_HEAD) || (bus.flit_id == FLIT_BODY) ||
                     (bus.flit_id == FLIT_TAIL);
        xfer       = (state_reg == ACTIVE) && (|(grant_reg & bus.req)) &&
                     (credits_reg != '0) && flit_valid;
        win_inc    = (win_reg >= 3'd4) ? 3'd0 : win_reg + 3'd1;
    end

    // Allocation FSM: grant on request, hold through the tail, watchdog release.
    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        ptr_next         = ptr_reg;
        win_next         = win_reg;
        stall_next       = stall_reg;
        timeout_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                stall_next = 12'd0;
                if (pick_valid) begin
                    grant_next = 5'(5'b00001 << pick_idx);
                    win_next   = pick_idx;
                    state_next = ACTIVE;
                end else begin
                    grant_next = 5'd0;
                end
            end
            ACTIVE: begin
                if (xfer) begin
                    stall_next = 12'd0;
                    if (bus.flit_id == FLIT_TAIL) begin
                        grant_next = 5'd0;
                        ptr_next   = win_inc;
                        state_next = IDLE;
                    end
                end else if (stall_reg >= STALL_LAST) begin
                    stall_next       = 12'd0;
                    grant_next       = 5'd0;
                    ptr_next         = win_inc;
                    timeout_err_next = 1'b1;
                    state_next       = IDLE;
                end else begin
                    stall_next = stall_reg + 12'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 5'd0;
                stall_next = 12'd0;
            end
        endcase
    end

    // Credit accounting: a simultaneous return and transfer cancel out;
    // a return into a full counter is an overflow and is flagged stickily.
    always_comb begin
        credits_next    = credits_reg;
        credit_err_next = credit_err_reg;
        if (xfer && !bus.credit_in) begin
            credits_next = credits_reg - CRED_ONE;
        end else if (!xfer && bus.credit_in) begin
            if (credits_reg >= CRED_FULL) begin
                credit_err_next = 1'b1;
            end else begin
                credits_next = credits_reg + CRED_ONE;
            end
        end
    end

    // State and status registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= 5'd0;
            ptr_reg         <= 3'd0;
            win_reg         <= 3'd0;
            stall_reg       <= 12'd0;
            credits_reg     <= CRED_FULL;
            timeout_err_reg <= 1'b0;
            credit_err_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            ptr_reg         <= ptr_next;
            win_reg         <= win_next;
            stall_reg       <= stall_next;
            credits_reg     <= credits_next;
            timeout_err_reg <= timeout_err_next;
            credit_err_reg  <= credit_err_next;
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.xfer        = xfer;
    assign bus.credits     = credits_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.credit_err  = credit_err_reg;
endmodule

// File: tb/tb_rr_output_allocator.sv
// Bench for rr_output_allocator: directed scenarios plus a randomized run
// checked against a packet-level reference model.
module tb_rr_output_allocator;
    localparam int BUF_DEPTH = 4;
    localparam int CRED_W    = 3;
    localparam int TIMEOUT   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_output_allocator_if #(.CRED_W(CRED_W)) bus ();

    rr_output_allocator #(
        .BUF_DEPTH(BUF_DEPTH),
        .CRED_W   (CRED_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: current owner (-1 = none), next preferred input,
    // credit count, consecutive stall count, error flags.
    int m_owner, m_rr, m_cred, m_stall;
    bit m_terr, m_cerr;

    function automatic logic [4:0] m_grant();
        return (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
    endfunction

    function automatic bit m_xfer();
        bit fv = (bus.flit_id == 3'b001) || (bus.flit_id == 3'b010) || (bus.flit_id == 3'b100);
        return (m_owner >= 0) && bus.req[m_owner] && (m_cred > 0) && fv;
    endfunction

    function automatic void m_reset();
        m_owner = -1; m_rr = 0; m_cred = BUF_DEPTH; m_stall = 0; m_terr = 0; m_cerr = 0;
    endfunction

    function automatic void m_step();
        bit x   = m_xfer();
        bit cin = bus.credit_in;
        if (cin && !x && m_cred == BUF_DEPTH) m_cerr = 1;
        else m_cred += int'(cin) - int'(x);
        m_terr = 0;
        if (m_owner < 0) begin
            m_stall = 0;
            for (int j = 0; j < 5; j++) begin
                int c = (m_rr + j) % 5;
                if (bus.req[c]) begin
                    m_owner = c;
                    break;
                end
            end
        end else if (x) begin
            m_stall = 0;
            if (bus.flit_id == 3'b100) begin
                m_rr = (m_owner + 1) % 5;
                m_owner = -1;
            end
        end else begin
            m_stall++;
            if (m_stall == TIMEOUT) begin
                m_rr = (m_owner + 1) % 5;
                m_owner = -1;
                m_stall = 0;
                m_terr = 1;
            end
        end
    endfunction

    // Drive one cycle's inputs just after the edge, then wait to the falling edge to sample.
    task automatic drive(input logic [4:0] r, input logic [2:0] f, input logic c);
        bus.req = r; bus.flit_id = f; bus.credit_in = c;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.flit_id = '0; bus.credit_in = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(5'd0, 3'b000, 1'b0);
        total++; if (bus.grant !== 5'd0) begin bad++; $display("FAIL reset_grant got=%b want=00000", bus.grant); end
        total++; if (bus.xfer !== 1'b0) begin bad++; $display("FAIL reset_xfer got=%b want=0", bus.xfer); end
        total++; if (bus.credits !== 3'd4) begin bad++; $display("FAIL reset_credits got=%0d want=4", bus.credits); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b want=0", bus.timeout_err); end
        total++; if (bus.credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err got=%b want=0", bus.credit_err); end
        tick();
    endtask

    task automatic test_basic_packet();
        logic [4:0] rq [6] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
        logic [2:0] fl [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b000};
        logic [4:0] eg [6] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
        logic       ex [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] ec [6] = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(rq[c], fl[c], 1'b0);
            total++; if (bus.grant !== eg[c]) begin bad++; $display("FAIL basic_grant cyc=%0d got=%b want=%b", c, bus.grant, eg[c]); end
            total++; if (bus.xfer !== ex[c]) begin bad++; $display("FAIL basic_xfer cyc=%0d got=%b want=%b", c, bus.xfer, ex[c]); end
            total++; if (bus.credits !== ec[c]) begin bad++; $display("FAIL basic_credits cyc=%0d got=%0d want=%0d", c, bus.credits, ec[c]); end
            $display("basic cyc=%0d grant=%b xfer=%b credits=%0d", c, bus.grant, bus.xfer, bus.credits);
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g;
        do_reset();
        for (int p = 0; p < 6; p++) begin
            exp_g = 5'(1 << (p % 5));
            drive(5'b11111, 3'b000, 1'b0);
            total++; if (bus.grant !== 5'd0) begin bad++; $display("FAIL rr_bubble pkt=%0d got=%b want=00000", p, bus.grant); end
            tick();
            drive(5'b11111, 3'b001, 1'b1);
            total++; if (bus.grant !== exp_g) begin bad++; $display("FAIL rr_grant pkt=%0d got=%b want=%b", p, bus.grant, exp_g); end
            total++; if (bus.xfer !== 1'b1) begin bad++; $display("FAIL rr_head_xfer pkt=%0d got=%b want=1", p, bus.xfer); end
            tick();
            drive(5'b11111, 3'b100, 1'b1);
            total++; if (bus.credits !== 3'd4) begin bad++; $display("FAIL rr_credits pkt=%0d got=%0d want=4", p, bus.credits); end
            $display("rr pkt=%0d grant=%b", p, bus.grant);
            tick();
        end
    endtask

    task automatic test_credit_stall();
        do_reset();
        drive(5'b00001, 3'b001, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(5'b00001, (k == 0) ? 3'b001 : 3'b010, 1'b0);
            total++; if (bus.xfer !== 1'b1) begin bad++; $display("FAIL stall_flow flit=%0d got=%b want=1", k, bus.xfer); end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(5'b00001, 3'b010, 1'b0);
            total++; if (bus.xfer !== 1'b0) begin bad++; $display("FAIL stall_blocked cyc=%0d got=%b want=0", k, bus.xfer); end
            total++; if (bus.credits !== 3'd0) begin bad++; $display("FAIL stall_credits cyc=%0d got=%0d want=0", k, bus.credits); end
            total++; if (bus.grant !== 5'b00001) begin bad++; $display("FAIL stall_grant_held cyc=%0d got=%b want=00001", k, bus.grant); end
            tick();
        end
        drive(5'b00001, 3'b010, 1'b1);
        total++; if (bus.xfer !== 1'b0) begin bad++; $display("FAIL stall_credit_cycle got=%b want=0", bus.xfer); end
        tick();
        drive(5'b00001, 3'b010, 1'b0);
        total++; if (bus.xfer !== 1'b1) begin bad++; $display("FAIL stall_one_more got=%b want=1", bus.xfer); end
        total++; if (bus.credits !== 3'd1) begin bad++; $display("FAIL stall_one_credit got=%0d want=1", bus.credits); end
        tick();
        drive(5'b00001, 3'b010, 1'b0);
        total++; if (bus.xfer !== 1'b0) begin bad++; $display("FAIL stall_again got=%b want=0", bus.xfer); end
        $display("credit_stall credits=%0d grant=%b", bus.credits, bus.grant);
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        drive(5'b00010, 3'b001, 1'b0);
        tick();
        for (int s = 1; s <= TIMEOUT; s++) begin
            drive(5'b00000, 3'b010, 1'b0);
            total++; if (bus.grant !== 5'b00010) begin bad++; $display("FAIL wd_grant_held stall=%0d got=%b want=00010", s, bus.grant); end
            total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL wd_early_pulse stall=%0d got=%b want=0", s, bus.timeout_err); end
            tick();
        end
        drive(5'b00101, 3'b000, 1'b0);
        total++; if (bus.grant !== 5'd0) begin bad++; $display("FAIL wd_release got=%b want=00000", bus.grant); end
        total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL wd_pulse got=%b want=1", bus.timeout_err); end
        tick();
        drive(5'b00101, 3'b000, 1'b0);
        total++; if (bus.grant !== 5'b00100) begin bad++; $display("FAIL wd_next_winner got=%b want=00100", bus.grant); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL wd_pulse_width got=%b want=0", bus.timeout_err); end
        $display("watchdog next grant=%b", bus.grant);
        tick();
    endtask

    task automatic test_credit_boundaries();
        do_reset();
        drive(5'b00001, 3'b001, 1'b0);
        tick();
        drive(5'b00001, 3'b001, 1'b1);
        total++; if (bus.xfer !== 1'b1) begin bad++; $display("FAIL cb_head_xfer got=%b want=1", bus.xfer); end
        tick();
        drive(5'b00001, 3'b010, 1'b1);
        total++; if (bus.credits !== 3'd4) begin bad++; $display("FAIL cb_cancel got=%0d want=4", bus.credits); end
        tick();
        drive(5'b00001, 3'b011, 1'b1);
        total++; if (bus.xfer !== 1'b0) begin bad++; $display("FAIL cb_invalid_flit got=%b want=0", bus.xfer); end
        total++; if (bus.credit_err !== 1'b0) begin bad++; $display("FAIL cb_err_early got=%b want=0", bus.credit_err); end
        tick();
        drive(5'b00001, 3'b100, 1'b0);
        total++; if (bus.credit_err !== 1'b1) begin bad++; $display("FAIL cb_overflow got=%b want=1", bus.credit_err); end
        total++; if (bus.credits !== 3'd4) begin bad++; $display("FAIL cb_saturate got=%0d want=4", bus.credits); end
        tick();
        drive(5'b00000, 3'b000, 1'b0);
        total++; if (bus.credits !== 3'd3) begin bad++; $display("FAIL cb_after_tail got=%0d want=3", bus.credits); end
        total++; if (bus.credit_err !== 1'b1) begin bad++; $display("FAIL cb_sticky got=%b want=1", bus.credit_err); end
        $display("credit_bounds credits=%0d credit_err=%b", bus.credits, bus.credit_err);
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(5'b01000, 3'b000, 1'b0); tick();
        drive(5'b01000, 3'b001, 1'b1); tick();
        drive(5'b01000, 3'b100, 1'b1); tick();
        drive(5'b00100, 3'b000, 1'b0); tick();
        drive(5'b00100, 3'b001, 1'b0); tick();
        drive(5'b00100, 3'b010, 1'b0);
        total++; if (bus.grant !== 5'b00100) begin bad++; $display("FAIL ar_pre_grant got=%b want=00100", bus.grant); end
        #1 rst = 1'b1;
        m_reset();
        #1;
        total++; if (bus.grant !== 5'd0) begin bad++; $display("FAIL ar_grant_drop got=%b want=00000", bus.grant); end
        total++; if (bus.credits !== 3'd4) begin bad++; $display("FAIL ar_credits got=%0d want=4", bus.credits); end
        #1 rst = 1'b0;
        bus.req = 5'b11010; bus.flit_id = 3'b000;
        tick();
        drive(5'b11010, 3'b000, 1'b0);
        total++; if (bus.grant !== 5'b00010) begin bad++; $display("FAIL ar_first_winner got=%b want=00010", bus.grant); end
        $display("async_reset first grant=%b", bus.grant);
        tick();
    endtask

    task automatic test_random();
        logic [4:0] r;
        logic [2:0] f;
        logic       c;
        int         sel;
        do_reset();
        r = 5'b00000;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            if ($urandom_range(0, 3) == 0) r = 5'($urandom);
            sel = $urandom_range(0, 7);
            f = (sel < 2) ? 3'b001 : (sel < 5) ? 3'b010 : (sel < 7) ? 3'b100 : 3'b011;
            c = ($urandom_range(0, 2) == 0);
            drive(r, f, c);
            total++; if (bus.grant !== m_grant()) begin bad++; $display("FAIL rnd_grant i=%0d got=%b want=%b", i, bus.grant, m_grant()); end
            total++; if (bus.xfer !== m_xfer()) begin bad++; $display("FAIL rnd_xfer i=%0d got=%b want=%b", i, bus.xfer, m_xfer()); end
            total++; if (bus.credits !== CRED_W'(m_cred)) begin bad++; $display("FAIL rnd_credits i=%0d got=%0d want=%0d", i, bus.credits, m_cred); end
            total++; if (bus.timeout_err !== m_terr) begin bad++; $display("FAIL rnd_timeout_err i=%0d got=%b want=%b", i, bus.timeout_err, m_terr); end
            total++; if (bus.credit_err !== m_cerr) begin bad++; $display("FAIL rnd_credit_err i=%0d got=%b want=%b", i, bus.credit_err, m_cerr); end
            if (m_xfer() && f == 3'b100) $display("rnd i=%0d packet done owner=%0d credits=%0d", i, m_owner, m_cred);
            tick();
        end
    endtask

    initial begin
        bus.req = '0; bus.flit_id = '0; bus.credit_in = 1'b0;
        m_reset();
        test_reset();
        test_basic_packet();
        test_round_robin();
        test_credit_stall();
        test_watchdog();
        test_credit_boundaries();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
